program_sequencer: RTL
======================

Name: program_sequencer

Overview:
- Host-side initiator for the core's start/done run protocol. The core waits for start low, runs until halt, raises done, then waits for start high before clearing done.
- This block drives start and consumes done. It sequences NUM_PROGS programs back-to-back and measures each program's run length in cycles.
- It detects a hung core by timeout.
- It sits beside the processor top level, in the FPGA wrapper and in the system bench.

Parameters:
NUM_PROGS, 3, number of programs run per sequence (1..15)
CNT_W, 16, width of cycle counter and cycle_count output
TIMEOUT, 16'hFFF0, RUN/ACK cycles allowed before error (must be < 2**CNT_W)
START_HOLD, 2, minimum cycles start held high before each launch (>=1)

Ports:
clk  input  1  system clock, rising-edge
reset_n  input  1  asynchronous, active-low reset
go  input  1  level; rising edge (sampled) starts a sequence
core_done  input  1  done from processor core
core_start  output  1  start to processor core; high = parked/ack, low = run
prog_idx  output  4  index of current/last program, 0..NUM_PROGS-1
cycle_count  output  CNT_W  run length of last completed program
count_valid  output  1  one-cycle pulse when cycle_count updates
busy  output  1  high in LAUNCH/RUN/ACK
all_done  output  1  high in FINISH
timeout_err  output  1  high in ERROR

Behaviour:
- Reset (async assert, sync deassert handled upstream): state IDLE.
  - core_start=1, prog_idx=0, cycle_count=0, count_valid=0, busy=0, all_done=0, timeout_err=0.
  - Internal hold and run counters are 0; go_q is 0.
- go edge detect: go_rise = go & ~go_q. go_q is registered every cycle. go_rise is ignored outside IDLE/FINISH/ERROR.
- IDLE: core_start=1. On go_rise: prog_idx<=0, hold counter<=0, go to LAUNCH.
- LAUNCH: core_start=1.
  - Hold counter increments each cycle.
  - Leave only when hold counter >= START_HOLD-1 AND core_done==0; stale done extends LAUNCH.
  - On exit: core_start<=0, run counter<=0, go to RUN.
- RUN: core_start=0.
  - Each edge with core_done==0: run counter+1.
  - If core_done==1: cycle_count<=run counter, count_valid pulses next cycle, core_start<=1, go to ACK.
  - cycle_count = number of RUN edges that sampled core_done==0. Done seen on the first RUN edge gives 0.
  - If run counter reaches TIMEOUT with core_done still 0: go to ERROR.
- ACK: core_start=1; the core clears done after seeing start high.
  - Wait for core_done==0; the run counter is reused and cleared on ACK entry.
  - If core_done==0 and prog_idx==NUM_PROGS-1: go to FINISH.
  - If core_done==0 otherwise: prog_idx+1, hold counter<=0, go to LAUNCH.
  - If core_done stays high for TIMEOUT cycles: go to ERROR.
- FINISH: all_done=1, core_start=1, prog_idx holds last value. On go_rise: restart as from IDLE.
- ERROR: timeout_err=1, core_start=1, prog_idx frozen at the failing program, cycle_count unchanged. On go_rise: restart as from IDLE, which clears timeout_err.
- Outputs are registered. busy, all_done and timeout_err decode from state registers.
- Simultaneous events:
  - go_rise in FINISH/ERROR takes priority, and the state goes to LAUNCH the same edge.
  - In RUN, done is evaluated before timeout on the same edge: done wins.
- Reset mid-RUN: core_start returns to 1 asynchronously and all state clears. The bench must also reset the core.
- Counters saturate; they never wrap, because TIMEOUT < 2**CNT_W.

Decomposition:
- Package proc_ctrl_pkg holds:
  - typedef enum logic [2:0] seq_state_t {IDLE, LAUNCH, RUN, ACK, FINISH, ERROR};
  - localparam START_PARK = 1'b1.
- One natural sub-module: edge_detect (registered rising-edge detector for go), reusable for other host inputs.
- The counters stay inline.

Test Plan:
- Reset with core model halting after 7 cycles; pulse go -> core_start low after 2 cycles high; cycle_count=7 with count_valid pulse, for prog_idx 0, 1, 2; then all_done=1, core_start=1.
- Core done on first RUN edge -> cycle_count=0, sequence advances normally.
- Stale core_done held high 5 cycles after ACK -> LAUNCH extends, core_start stays 1 until done drops, no spurious count.
- Core never raises done, TIMEOUT=20 -> timeout_err=1 after 20 RUN cycles, prog_idx frozen, core_start=1; go pulse clears error and restarts at prog_idx=0.
- go pulsed during RUN -> ignored, counts unchanged; go pulse in FINISH -> new 3-program sequence, counts 4/9/12 reported in order.
- reset_n asserted mid-RUN -> core_start=1 and all outputs at reset values immediately (asynchronous), before the next clk edge.

Source files
------------

// File: rtl/proc_ctrl_pkg.sv
// Shared types for the host-side run-protocol sequencer.
package proc_ctrl_pkg;

   typedef enum logic [2:0] {IDLE, LAUNCH, RUN, ACK, FINISH, ERROR} seq_state_t;

   // Level of core_start that parks the core (high = parked / acknowledge).
   localparam logic START_PARK = 1'b1;

endpackage

// File: rtl/program_sequencer_edge_detect.sv
// Registered rising-edge detector for a level host input.
module edge_detect (
   input  logic clk,
   input  logic reset_n,
   input  logic d,
   output logic rise
);

   logic d_q;

   // Remember last cycle's level so a held level yields a single pulse.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) d_q <= 1'b0;
      else          d_q <= d;
   end

   assign rise = d & ~d_q;

endmodule

// File: rtl/program_sequencer.sv
// Drives the core's start/done handshake for NUM_PROGS back-to-back programs,
// reports each program's run length and flags a hung core by timeout.
module program_sequencer
   import proc_ctrl_pkg::*;
#(
   parameter int NUM_PROGS  = 3,
   parameter int CNT_W      = 16,
   parameter int TIMEOUT    = 'hFFF0,
   parameter int START_HOLD = 2
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             go,
   input  logic             core_done,
   output logic             core_start,
   output logic [3:0]       prog_idx,
   output logic [CNT_W-1:0] cycle_count,
   output logic             count_valid,
   output logic             busy,
   output logic             all_done,
   output logic             timeout_err
);

   localparam int               HOLD_W    = (START_HOLD > 1) ? $clog2(START_HOLD) : 1;
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(START_HOLD - 1);
   localparam logic [CNT_W-1:0]  TO_LAST   = CNT_W'(TIMEOUT - 1);
   localparam logic [3:0]        IDX_LAST  = 4'(NUM_PROGS - 1);

   seq_state_t        state, state_d;
   logic              start_d, cv_d;
   logic [3:0]        idx_d;
   logic [CNT_W-1:0]  cnt_d, run_cnt, run_d;
   logic [HOLD_W-1:0] hold_cnt, hold_d;
   logic              go_rise;

   edge_detect u_go_edge (
      .clk     (clk),
      .reset_n (reset_n),
      .d       (go),
      .rise    (go_rise)
   );

   // State, registered outputs and inline counters.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state       <= IDLE;
         core_start  <= START_PARK;
         prog_idx    <= '0;
         cycle_count <= '0;
         count_valid <= 1'b0;
         hold_cnt    <= '0;
         run_cnt     <= '0;
      end else begin
         state       <= state_d;
         core_start  <= start_d;
         prog_idx    <= idx_d;
         cycle_count <= cnt_d;
         count_valid <= cv_d;
         hold_cnt    <= hold_d;
         run_cnt     <= run_d;
      end
   end

   // Next-state and next-output decode; done is checked ahead of timeout.
   always_comb begin
      state_d = state;
      start_d = core_start;
      idx_d   = prog_idx;
      cnt_d   = cycle_count;
      cv_d    = 1'b0;
      hold_d  = hold_cnt;
      run_d   = run_cnt;
      case (state)
         IDLE, FINISH, ERROR: begin
            start_d = START_PARK;
            if (go_rise) begin
               state_d = LAUNCH;
               idx_d   = '0;
               hold_d  = '0;
            end
         end
         LAUNCH: begin
            start_d = START_PARK;
            if (hold_cnt < HOLD_LAST) hold_d = hold_cnt + 1'b1;
            // A stale done from the previous run keeps the core parked.
            if (hold_cnt >= HOLD_LAST && !core_done) begin
               start_d = ~START_PARK;
               run_d   = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            start_d = ~START_PARK;
            if (core_done) begin
               cnt_d   = run_cnt;
               cv_d    = 1'b1;
               start_d = START_PARK;
               run_d   = '0;
               state_d = ACK;
            end else begin
               run_d = run_cnt + 1'b1;
               if (run_cnt >= TO_LAST) begin
                  start_d = START_PARK;
                  state_d = ERROR;
               end
            end
         end
         ACK: begin
            start_d = START_PARK;
            if (!core_done) begin
               if (prog_idx == IDX_LAST) begin
                  state_d = FINISH;
               end else begin
                  idx_d   = prog_idx + 1'b1;
                  hold_d  = '0;
                  state_d = LAUNCH;
               end
            end else begin
               run_d = run_cnt + 1'b1;
               if (run_cnt >= TO_LAST) state_d = ERROR;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign busy        = (state == LAUNCH) || (state == RUN) || (state == ACK);
   assign all_done    = (state == FINISH);
   assign timeout_err = (state == ERROR);

endmodule
